tx_gearbox_66b_32b: RTL

TX_GEARBOX_66B_32B -- requirements
Module: tx_gearbox_66b_32b

---
 rtl/tx_gearbox_66b_32b.sv | 97 +++++++++
 1 files changed

// File: rtl/tx_gearbox_66b_32b.sv
// 66b-to-32b transmit gearbox: a 66-cycle sequence accepts 64 half-blocks and emits 32-bit words.
// Optional sync-header check compiled in when TX_GEARBOX_HEAD_CHECK_EN is defined.
module tx_gearbox_66b_32b #(
  parameter int unsigned BIT_REVERSE = 0,
  parameter int unsigned START_SEQ   = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  head_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic [6:0]  seq_o,
  output logic        head_err_o
);

  localparam logic [6:0] SEQ_LAST = 7'd65;
  localparam logic [6:0] SEQ_INIT = 7'(START_SEQ);

  logic [6:0]  seq_q, seq_d;
  logic [6:0]  lvl_q, lvl_d;
  logic [63:0] res_q, res_d;
  logic [31:0] data_q, data_d;
  logic [33:0] app;
  logic [6:0]  app_len;
  logic [7:0]  sum;
  logic [95:0] window;

  assign ready_o = (seq_q < 7'd64);
  assign seq_o   = seq_q;
  assign data_o  = data_q;

  always_comb begin
    app     = '0;
    app_len = '0;
    if (ready_o) begin
      if (!seq_q[0]) begin
        app     = {data_i, head_i};
        app_len = 7'd34;
      end else begin
        app     = {2'b00, data_i};
        app_len = 7'd32;
      end
    end

    // New bits land directly above the residual; bits above the level are always zero.
    window = {32'h0, res_q} | ({62'h0, app} << lvl_q);
    sum    = {1'b0, lvl_q} + {1'b0, app_len};

    // Level clamps at 0 only when a reset left the buffer behind the schedule.
    if (sum >= 8'd32) lvl_d = 7'(sum - 8'd32);
    else              lvl_d = '0;
    res_d = window[95:32];

    seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 7'd1;

    data_d = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (BIT_REVERSE != 0) data_d[i] = window[31-i];
      else                  data_d[i] = window[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seq_q  <= SEQ_INIT;
      lvl_q  <= '0;
      res_q  <= '0;
      data_q <= '0;
    end else begin
      seq_q  <= seq_d;
      lvl_q  <= lvl_d;
      res_q  <= res_d;
      data_q <= data_d;
    end
  end

`ifdef TX_GEARBOX_HEAD_CHECK_EN
  logic head_err_q, head_err_d;

  always_comb begin
    head_err_d = head_err_q;
    if (ready_o && !seq_q[0] && (head_i == 2'b00 || head_i == 2'b11))
      head_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) head_err_q <= 1'b0;
    else          head_err_q <= head_err_d;
  end

  assign head_err_o = head_err_q;
`else
  assign head_err_o = 1'b0;
`endif

endmodule
